// File: rtl/vx_amo_rmw_ctrl.sv
// Read-modify-write sequencer for RISC-V AMOs: reads the target word, writes back the
// external AMO ALU result and returns the old memory value, one request at a time.
module vx_amo_rmw_ctrl #(
  parameter int TAGW  = 8,
  parameter int DATAW = 32,
  parameter int ADDRW = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [DATAW-1:0] req_data,
  input  logic [TAGW-1:0]  req_tag,

  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_rw,
  output logic [ADDRW-1:0] mem_req_addr,
  output logic [DATAW-1:0] mem_req_data,
  input  logic             mem_rsp_valid,
  input  logic [DATAW-1:0] mem_rsp_data,
  input  logic             mem_rsp_err,

  output logic [4:0]       alu_op,
  output logic [DATAW-1:0] alu_in1,
  output logic [DATAW-1:0] alu_in2,
  input  logic [DATAW-1:0] alu_result,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DATAW-1:0] rsp_data,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_err,

  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [4:0]       op_q;
  logic [ADDRW-1:0] addr_q;
  logic [DATAW-1:0] data_q;
  logic [TAGW-1:0]  tag_q;
  logic [DATAW-1:0] old_q;
  logic             err_q;

  logic misaligned;

  assign misaligned = (req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory responses only matter in the two wait states; anywhere else they fall through.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_data  = '0;
    rsp_valid     = 1'b0;
    busy          = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_d = misaligned ? RSP : RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = mem_rsp_err ? RSP : WR_REQ;
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_data  = alu_result;
        if (mem_req_ready) begin
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // A misaligned request skips memory entirely and reports a zero old value with an error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
      old_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
            tag_q  <= req_tag;
            old_q  <= '0;
            err_q  <= misaligned;
          end
        end
        RD_WAIT: begin
          if (mem_rsp_valid) begin
            old_q <= mem_rsp_data;
            if (mem_rsp_err) begin
              err_q <= 1'b1;
            end
          end
        end
        WR_WAIT: begin
          if (mem_rsp_valid) begin
            err_q <= mem_rsp_err;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            err_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_req_addr = {addr_q[ADDRW-1:2], 2'b00};

  // ALU operands come only from registers so alu_result stays stable across write stalls.
  assign alu_op  = op_q;
  assign alu_in1 = old_q;
  assign alu_in2 = data_q;

  assign rsp_data = old_q;
  assign rsp_tag  = tag_q;
  assign rsp_err  = err_q;

endmodule

// File: tb/tb_vx_amo_rmw_ctrl.sv
// Bench for vx_amo_rmw_ctrl: behavioural memory + AMO ALU, table of single AMOs,
// then back-pressure and reset-abandon sequences. Responses are scored from a queue.
module tb_vx_amo_rmw_ctrl;

  localparam logic [4:0] AMO_ADD  = 5'h00;
  localparam logic [4:0] AMO_SWAP = 5'h01;
  localparam logic [4:0] AMO_XOR  = 5'h04;
  localparam logic [4:0] AMO_OR   = 5'h08;
  localparam logic [4:0] AMO_AND  = 5'h0C;
  localparam logic [4:0] AMO_MIN  = 5'h10;
  localparam logic [4:0] AMO_MAX  = 5'h14;
  localparam logic [4:0] AMO_MINU = 5'h18;
  localparam logic [4:0] AMO_MAXU = 5'h1C;
  localparam int NV = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_addr, req_data;
  logic [7:0]  req_tag;
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic [4:0]  alu_op;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic        busy;

  vx_amo_rmw_ctrl #(.TAGW(8), .DATAW(32), .ADDRW(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Combinational AMO ALU using the RISC-V funct5 opcode values.
  always_comb begin
    case (alu_op)
      AMO_ADD:  alu_result = alu_in1 + alu_in2;
      AMO_SWAP: alu_result = alu_in2;
      AMO_XOR:  alu_result = alu_in1 ^ alu_in2;
      AMO_OR:   alu_result = alu_in1 | alu_in2;
      AMO_AND:  alu_result = alu_in1 & alu_in2;
      AMO_MIN:  alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? alu_in1 : alu_in2;
      AMO_MAX:  alu_result = ($signed(alu_in1) > $signed(alu_in2)) ? alu_in1 : alu_in2;
      AMO_MINU: alu_result = (alu_in1 < alu_in2) ? alu_in1 : alu_in2;
      AMO_MAXU: alu_result = (alu_in1 > alu_in2) ? alu_in1 : alu_in2;
      default:  alu_result = 32'hFFFF_FFFF;
    endcase
  end

  // Behavioural memory, all driving done on the falling edge.
  logic [31:0] mem [logic [31:0]];
  int          stall_cfg, rsp_extra;
  logic        rd_fault, wr_fault;
  int          rd_count = 0, wr_count = 0, rsp_sent = 0;
  logic [31:0] last_rd_addr = 0, last_wr_addr = 0, last_wr_data = 0;
  int          stall_left = 0, rsp_due = 0;
  logic        prev_stalled = 1'b0, rsp_pending = 1'b0, pend_err = 1'b0, sv_rw = 1'b0;
  logic [31:0] pend_data = 0, sv_addr = 0, sv_data = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      mem_rsp_data  = 32'h0;
      if (rsp_pending) begin
        rsp_due--;
        if (rsp_due == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = pend_data;
          mem_rsp_err   = pend_err;
          rsp_pending   = 1'b0;
          rsp_sent++;
        end
      end
      if (mem_req_valid) begin
        if (prev_stalled) begin
          check_output("stall_addr", mem_req_addr, sv_addr);
          check_output("stall_rw", {31'b0, mem_req_rw}, {31'b0, sv_rw});
          check_output("stall_data", mem_req_data, sv_data);
        end else begin
          stall_left = stall_cfg;
        end
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
          prev_stalled = 1'b1;
          sv_addr = mem_req_addr;
          sv_rw   = mem_req_rw;
          sv_data = mem_req_data;
        end else begin
          mem_req_ready = 1'b1;
          prev_stalled  = 1'b0;
          check_output("mem_addr_aligned", {30'b0, mem_req_addr[1:0]}, 32'h0);
          if (!mem_req_rw) begin
            rd_count++;
            last_rd_addr = mem_req_addr;
            pend_data    = mem_read(mem_req_addr);
            pend_err     = rd_fault;
          end else begin
            wr_count++;
            last_wr_addr = mem_req_addr;
            last_wr_data = mem_req_data;
            if (!wr_fault) mem[mem_req_addr] = mem_req_data;
            pend_data = 32'hA5A5_A5A5;
            pend_err  = wr_fault;
          end
          rsp_pending = 1'b1;
          rsp_due     = 1 + rsp_extra;
        end
      end else begin
        mem_req_ready = 1'b0;
        prev_stalled  = 1'b0;
      end
    end
  end

  // Response scoreboard: entries pushed at acceptance, popped at the writeback handshake.
  typedef struct {
    logic [31:0] data;
    logic [7:0]  tag;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int          rsp_hold_cfg = 0, hold_left = 0, first_cyc = 0, last_hs_cyc = 0, last_acc = 0;
  logic        in_rsp = 1'b0, cap_err = 1'b0;
  logic [31:0] cap_data = 0;
  logic [7:0]  cap_tag = 0;

  initial begin
    exp_t e;
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset && rsp_valid) begin
        if (!in_rsp) begin
          in_rsp       = 1'b1;
          first_cyc    = cyc;
          cap_data     = rsp_data;
          cap_tag      = rsp_tag;
          cap_err      = rsp_err;
          hold_left    = rsp_hold_cfg;
          rsp_hold_cfg = 0;
        end else begin
          check_output("rsp_hold_data", rsp_data, cap_data);
          check_output("rsp_hold_tag", {24'b0, rsp_tag}, {24'b0, cap_tag});
          check_output("rsp_hold_err", {31'b0, rsp_err}, {31'b0, cap_err});
        end
        if (hold_left > 0) begin
          rsp_ready = 1'b0;
          hold_left--;
          check_output("req_ready_during_rsp", {31'b0, req_ready}, 32'h0);
        end else begin
          rsp_ready   = 1'b1;
          in_rsp      = 1'b0;
          last_hs_cyc = cyc + 1;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_rsp: got tag %02h data %08h, required no response", rsp_tag, rsp_data);
          end else begin
            e = sb.pop_front();
            check_output("rsp_data", rsp_data, e.data);
            check_output("rsp_tag", {24'b0, rsp_tag}, {24'b0, e.tag});
            check_output("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            if (e.lat != 0) check_output("rsp_latency", first_cyc - e.acc + 1, e.lat);
          end
        end
      end else begin
        rsp_ready = 1'b1;
        in_rsp    = 1'b0;
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after acceptance, req_valid still high.
  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] data,
                                input logic [7:0] tag, input logic [31:0] exp_data, input logic exp_err,
                                input int exp_lat, input bit push);
    exp_t e;
    int n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    req_tag   = tag;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got req_ready=0 for %0d cycles, required 1", n);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (push) begin
      e.data = exp_data;
      e.tag  = tag;
      e.err  = exp_err;
      e.lat  = exp_lat;
      e.acc  = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got %0d pending responses busy=%0b, required 0 and 0", sb.size(), busy);
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [7:0]  tag;
    logic [31:0] init;
    logic        rdf;
    logic        wrf;
    int          stall;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_reads;
    int          exp_writes;
    logic [31:0] exp_mem;
    int          exp_lat;
  } vec_t;
  vec_t vecs [NV];

  int r0, w0, s0, n;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_op = 5'h0; req_addr = 32'h0; req_data = 32'h0; req_tag = 8'h0;
    stall_cfg = 0; rsp_extra = 0; rd_fault = 1'b0; wr_fault = 1'b0;

    vecs[0]  = '{AMO_ADD,  32'h0000_0100, 32'h0000_0003, 8'h2A, 32'h0000_0005, 1'b0, 1'b0, 0, 32'h0000_0005, 1'b0, 1, 1, 32'h0000_0008, 5};
    vecs[1]  = '{AMO_SWAP, 32'h0000_0204, 32'h1234_5678, 8'h11, 32'hDEAD_BEEF, 1'b0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, 1, 1, 32'h1234_5678, 11};
    vecs[2]  = '{AMO_OR,   32'h0000_0102, 32'h0000_00F0, 8'h33, 32'h0000_0055, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 0, 0, 32'h0000_0055, 1};
    vecs[3]  = '{AMO_MAX,  32'h0000_0300, 32'h0000_0009, 8'h44, 32'h0000_0007, 1'b1, 1'b0, 0, 32'h0000_0007, 1'b1, 1, 0, 32'h0000_0007, 3};
    vecs[4]  = '{AMO_MAX,  32'h0000_0304, 32'h0000_0001, 8'h45, 32'h8000_0000, 1'b0, 1'b1, 0, 32'h8000_0000, 1'b1, 1, 1, 32'h8000_0000, 5};
    vecs[5]  = '{AMO_XOR,  32'h0000_0400, 32'hFF00_FF00, 8'h50, 32'hF0F0_F0F0, 1'b0, 1'b0, 0, 32'hF0F0_F0F0, 1'b0, 1, 1, 32'h0FF0_0FF0, 5};
    vecs[6]  = '{AMO_AND,  32'h0000_0404, 32'h00FF_00FF, 8'h51, 32'h0000_FFFF, 1'b0, 1'b0, 0, 32'h0000_FFFF, 1'b0, 1, 1, 32'h0000_00FF, 5};
    vecs[7]  = '{AMO_MINU, 32'h0000_0408, 32'h0000_0005, 8'h52, 32'h8000_0000, 1'b0, 1'b0, 0, 32'h8000_0000, 1'b0, 1, 1, 32'h0000_0005, 5};
    vecs[8]  = '{AMO_MIN,  32'h0000_040C, 32'h0000_0005, 8'h53, 32'h8000_0000, 1'b0, 1'b0, 0, 32'h8000_0000, 1'b0, 1, 1, 32'h8000_0000, 5};
    vecs[9]  = '{AMO_MAXU, 32'h0000_0410, 32'hFFFF_FFFE, 8'h54, 32'h0000_0003, 1'b0, 1'b0, 0, 32'h0000_0003, 1'b0, 1, 1, 32'hFFFF_FFFE, 5};
    vecs[10] = '{5'h02,    32'h0000_0414, 32'h0000_0001, 8'h55, 32'h0000_1234, 1'b0, 1'b0, 0, 32'h0000_1234, 1'b0, 1, 1, 32'hFFFF_FFFF, 5};
    vecs[11] = '{AMO_ADD,  32'h0000_0803, 32'h0000_0001, 8'h77, 32'h0000_0099, 1'b0, 1'b0, 0, 32'h0000_0000, 1'b1, 0, 0, 32'h0000_0099, 1};
    vecs[12] = '{AMO_ADD,  32'hFFFF_FFFC, 32'hFFFF_FFFF, 8'hC3, 32'h0000_0001, 1'b0, 1'b0, 0, 32'h0000_0001, 1'b0, 1, 1, 32'h0000_0000, 5};

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", {31'b0, busy}, 32'h0);
    check_output("reset_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check_output("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check_output("reset_alu_in1", alu_in1, 32'h0);
    check_output("reset_alu_in2", alu_in2, 32'h0);
    check_output("reset_rsp_tag", {24'b0, rsp_tag}, 32'h0);
    reset = 1'b1;
    #1 check_output("reset_req_ready", {31'b0, req_ready}, 32'h1);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      mem[vecs[i].addr & ~32'h3] = vecs[i].init;
      stall_cfg = vecs[i].stall;
      rd_fault  = vecs[i].rdf;
      wr_fault  = vecs[i].wrf;
      r0 = rd_count;
      w0 = wr_count;
      apply_stimulus(vecs[i].op, vecs[i].addr, vecs[i].rs2, vecs[i].tag,
                     vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat, 1'b1);
      req_valid = 1'b0;
      wait_done();
      check_output($sformatf("v%0d_reads", i), rd_count - r0, vecs[i].exp_reads);
      check_output($sformatf("v%0d_writes", i), wr_count - w0, vecs[i].exp_writes);
      check_output($sformatf("v%0d_mem", i), mem_read(vecs[i].addr & ~32'h3), vecs[i].exp_mem);
      if (vecs[i].exp_reads > 0)
        check_output($sformatf("v%0d_rd_addr", i), last_rd_addr, vecs[i].addr & ~32'h3);
      if (vecs[i].exp_writes > 0)
        check_output($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].addr & ~32'h3);
    end
    stall_cfg = 0; rd_fault = 1'b0; wr_fault = 1'b0;

    // Writeback back-pressure with the next request already waiting.
    mem[32'h500] = 32'd10;
    mem[32'h504] = 32'd1;
    rsp_hold_cfg = 10;
    apply_stimulus(AMO_ADD, 32'h500, 32'd20, 8'h41, 32'd10, 1'b0, 5, 1'b1);
    apply_stimulus(AMO_SWAP, 32'h504, 32'd2, 8'h42, 32'd1, 1'b0, 5, 1'b1);
    check_output("next_accept_gap", last_acc - last_hs_cyc, 32'd1);
    req_valid = 1'b0;
    wait_done();
    check_output("hold_mem_a", mem_read(32'h500), 32'd30);
    check_output("hold_mem_b", mem_read(32'h504), 32'd2);

    // Reset while waiting for a slow write ack; the ack then arrives as a stray.
    rsp_extra = 5;
    mem[32'h700] = 32'h11;
    w0 = wr_count;
    apply_stimulus(AMO_ADD, 32'h700, 32'h22, 8'h99, 32'h0, 1'b0, 0, 1'b0);
    req_valid = 1'b0;
    n = 0;
    while (wr_count == w0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("rst_write_issued", wr_count - w0, 32'd1);
    s0 = rsp_sent;
    @(negedge clk);
    check_output("rst_pre_busy", {31'b0, busy}, 32'h1);
    check_output("rst_pre_old", alu_in1, 32'h11);
    #2 reset = 1'b0;
    #1;
    check_output("rst_busy", {31'b0, busy}, 32'h0);
    check_output("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
    check_output("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check_output("rst_alu_in1", alu_in1, 32'h0);
    check_output("rst_alu_in2", alu_in2, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 check_output("rst_req_ready", {31'b0, req_ready}, 32'h1);
    n = 0;
    while (rsp_sent == s0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("stray_rsp_seen", rsp_sent - s0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("stray_busy", {31'b0, busy}, 32'h0);
      check_output("stray_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check_output("stray_mem_req_valid", {31'b0, mem_req_valid}, 32'h0);
    end
    rsp_extra = 0;

    mem[32'h600] = 32'd1;
    apply_stimulus(AMO_ADD, 32'h600, 32'd1, 8'h5A, 32'd1, 1'b0, 5, 1'b1);
    req_valid = 1'b0;
    wait_done();
    check_output("recover_mem", mem_read(32'h600), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vx_amo_rmw_ctrl.md
Name: vx_amo_rmw_ctrl

Overview:
Read-modify-write sequencer for RISC-V AMO instructions. It accepts one AMO request from the LSU issue side, reads the target word from memory, and drives the combinational AMO ALU (old value, rs2 data). It then writes the ALU result back and returns the old memory value as the rd writeback. One request is in flight at a time, and the block sits between LSU dispatch and the data-cache request port.

Parameters:
TAGW, 8, width of the request/response tag carried through unchanged
DATAW, 32, data width; only 32 is supported
ADDRW, 32, byte-address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  1  AMO request valid
req_ready  out  1  block can accept a request
req_op  in  5  AMO opcode, `INST_AMO_* encoding
req_addr  in  ADDRW  byte address
req_data  in  DATAW  rs2 operand
req_tag  in  TAGW  opaque tag
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  0=read, 1=write
mem_req_addr  out  ADDRW  word-aligned address
mem_req_data  out  DATAW  write data
mem_rsp_valid  in  1  memory response/ack valid, always accepted while waiting
mem_rsp_data  in  DATAW  read data; ignored on write ack
mem_rsp_err  in  1  access fault
alu_op  out  5  to AMO ALU
alu_in1  out  DATAW  to AMO ALU: old memory value
alu_in2  out  DATAW  to AMO ALU: rs2 operand
alu_result  in  DATAW  from AMO ALU, combinational
rsp_valid  out  1  writeback valid
rsp_ready  in  1  writeback accepted
rsp_data  out  DATAW  old memory value (rd)
rsp_tag  out  TAGW  tag of the completed request
rsp_err  out  1  1 = misaligned or memory fault
busy  out  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All registered fields (op_q, addr_q, data_q, tag_q, old_q, err_q) cleared to 0.
  - Outputs: mem_req_valid=0, rsp_valid=0, busy=0, req_ready=1 once reset deasserts.
  - Reset mid-operation abandons the transaction with no response; an outstanding memory response arriving after reset is ignored in IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture op/addr/data/tag.
  - If req_addr[1:0]!=0, set err_q=1 and old_q=0, then go to RSP with no memory access.
  - Otherwise go to RD_REQ.
- RD_REQ:
  - mem_req_valid=1, rw=0, addr={addr_q[ADDRW-1:2],2'b00}.
  - Hold all request signals stable until mem_req_ready; on the handshake go to RD_WAIT.
- RD_WAIT:
  - On mem_rsp_valid, old_q<=mem_rsp_data.
  - If mem_rsp_err=1: err_q=1, go to RSP, skip the write.
  - Otherwise go to WR_REQ.
  - A response in the same cycle as the read handshake is not accepted; memory responds at the earliest one cycle after the handshake.
- WR_REQ:
  - mem_req_valid=1, rw=1, same address, mem_req_data=alu_result.
  - alu_result is stable because alu_in1=old_q, alu_in2=data_q, alu_op=op_q are registered.
  - On mem_req_ready go to WR_WAIT.
- WR_WAIT:
  - On mem_rsp_valid, err_q<=mem_rsp_err and go to RSP.
  - old_q is unchanged; write-ack data is ignored.
- RSP:
  - rsp_valid=1, rsp_data=old_q, rsp_tag=tag_q, rsp_err=err_q.
  - Hold all of these until rsp_ready; on the handshake go to IDLE and clear err_q.
  - The next request is accepted in the cycle after the response handshake, never in the same cycle.
- The ALU ports are driven in every state. The values are don't-care outside WR_REQ but must be the registered fields, never raw inputs.
- mem_rsp_valid outside RD_WAIT or WR_WAIT is ignored and causes no state change.
- Unknown opcode: the sequence runs normally and writes whatever the ALU returns (0xFFFFFFFF for the default case).
- Minimum latency with zero-wait memory and rsp_ready held at 1: request accepted on edge 0, rsp_valid in the 5th cycle after acceptance.
  - Cycle 1 RD_REQ, 2 RD_WAIT, 3 WR_REQ, 4 WR_WAIT, 5 RSP.
- Back-pressure on mem_req_ready or rsp_ready only stretches the corresponding state; no data is lost or duplicated.

Test Plan:
- AMOADD at addr 0x100, mem[0x100]=5, rs2=3, tag=0x2A, zero-wait memory -> exactly one read to 0x100, then one write of 8. rsp_data=5, rsp_tag=0x2A, rsp_err=0, rsp_valid 5 cycles after acceptance.
- AMOSWAP at addr 0x204, mem=0xDEADBEEF, rs2=0x12345678, mem_req_ready low for 3 cycles in each of RD_REQ and WR_REQ -> request fields stay stable while stalled. Write data=0x12345678, rsp_data=0xDEADBEEF.
- Misaligned AMOOR at addr 0x102 -> no mem_req_valid ever. rsp_valid the cycle after acceptance with rsp_err=1, rsp_data=0.
- AMOMAX with a read response carrying mem_rsp_err=1 -> no write issued, rsp_err=1. Second case, fault on the write ack -> rsp_err=1 and rsp_data equals the read value.
- rsp_ready held low for 10 cycles with req_valid asserted -> req_ready=0 and rsp fields stable throughout. After the handshake, the next request is accepted one cycle later.
- reset pulled low during WR_WAIT, then a stray mem_rsp_valid arrives after reset deasserts -> outputs go to reset values immediately. The stray response is ignored, state stays IDLE, and no rsp_valid is produced.
